mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multi-cycle control unit that sequences `MIPS_Datapath`: it decodes the fetched instruction and drives the datapath's `regWrite`, `memWrite`, `memRead`, `branch` and `aluControl` strobes, plus PC/IR/mux selects, one phase per clock. It stalls on a memory ready handshake. It replaces the hand-driven control inputs at the datapath boundary, so each instruction completes without external sequencing.

## Interface
- No parameters; widths fixed by MIPS32.
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; returns FSM to FETCH.
- `instruction`  in  32  instruction word from memory/IR.
- `zero`  in  1  ALU zero flag from datapath.
- `mem_ready`  in  1  memory completes current read/write this cycle.
- `ir_write`  out  1  load instruction register.
- `pc_write`  out  1  update PC.
- `pc_src`  out  2  00 PC+4, 01 branch target, 10 jump target.
- `regWrite`, `memRead`, `memWrite`, `branch`  out  1 each  datapath strobes.
- `aluControl`  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `alu_src`  out  1  1 = sign-extended immediate as ALU operand B.
- `reg_dst`  out  1  1 = rd, 0 = rt.
- `mem_to_reg`  out  1  1 = write-back from memory data.
- `state`  out  3  current FSM state, for debug.
- `illegal_op`  out  1  present only with `MIPS_CTRL_ILLEGAL_TRAP_EN`.

## Operation
- Supported: R-type (funct 32 ADD, 34 SUB, 36 AND, 37 OR, 42 SLT), LW (35), SW (43), BEQ (4), ADDI (8), J (2).
- Opcode/funct latched internally on the cycle `ir_write`=1; later decoding uses the latched copy only.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH: `memRead`=1. On `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_src`=00, go to DECODE. Otherwise hold.
- DECODE: J asserts `pc_write`=1, `pc_src`=10 and goes to FETCH. Supported opcodes go to EXEC. Anything else, including an unsupported R-type funct, is illegal (see Configuration).
- EXEC:
  - R-type: `aluControl` from funct, go to WB.
  - LW/SW: `alu_src`=1, ADD, go to MEM.
  - ADDI: `alu_src`=1, ADD, go to WB.
  - BEQ: SUB, `branch`=1, `pc_src`=01, `pc_write`=`zero`, go to FETCH.
- MEM: LW asserts `memRead`=1, SW asserts `memWrite`=1, with `alu_src`=1 and ADD held. Strobe is held until `mem_ready`. Then LW goes to WB and SW goes to FETCH.
- WB: `regWrite`=1 for exactly one cycle, `reg_dst`=1 for R-type only, `mem_to_reg`=1 for LW only, then go to FETCH.
- Outputs are Moore: a decode of the registered state plus the latched opcode. Unlisted outputs are 0 in every state.

## Timing
- Reset: state=FETCH. While `reset`=1, all outputs are 0 (including `memRead`) and `illegal_op`=0.
- Cycles per instruction with `mem_ready` always 1: J 2, BEQ 3, R/ADDI 4, SW 4, LW 5. Each `mem_ready`-low cycle in FETCH/MEM adds one.
- `mem_ready` is ignored outside FETCH and MEM.
- `mem_ready` held low keeps the FSM stalled indefinitely, with strobes stable.
- Reset asserted mid-instruction aborts immediately: no `regWrite`/`memWrite` pulse occurs after the `reset` edge.
- `regWrite` and `memWrite` are never asserted in the same cycle.
- BEQ samples `zero` in the EXEC cycle only.

## Configuration
- `MIPS_CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal instruction sends DECODE to TRAP.
  - TRAP asserts `illegal_op`=1 with all strobes 0 and stays there until reset.
- Not defined:
  - The `illegal_op` port is absent.
  - An illegal instruction behaves as a NOP: DECODE goes to FETCH with no writes.

## Structure
- Shared package `mips_pkg`: opcode constants, funct constants, `aluControl` encodings, `pc_src` encodings, state enum.
- Sub-module `mips_alu_decoder`: combinational funct/opcode-class to `aluControl` and legality flag. Its legality flag feeds the DECODE illegal check.
- Top holds the FSM, the opcode/funct latch and the output decode.

## Test plan
- ADD $3,$1,$2 (0x00221820), `mem_ready`=1 → states 0,1,2,4. `aluControl`=010 in EXEC. `regWrite`=1, `reg_dst`=1 in cycle 4 only.
- LW $4,4($1) (0x8C240004), `mem_ready` low 2 cycles in MEM → `memRead` held 3 cycles, then WB with `mem_to_reg`=1. Total 7 cycles.
- SW $5,8($1) (0xAC250008) → `memWrite`=1 in MEM, `regWrite` never 1, return to FETCH after 4 cycles.
- BEQ with `zero`=1 then `zero`=0 → `pc_write`=1/`pc_src`=01 in EXEC for the first, `pc_write`=0 for the second. 3 cycles each.
- J 10 (0x0800000A) → `pc_write`=1, `pc_src`=10 in DECODE; next state FETCH.
- Opcode 0x3F → with macro: TRAP, `illegal_op`=1 until reset. Without macro: FETCH after DECODE, no strobes. Also assert reset during MEM of SW → `memWrite` drops immediately and state=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared encodings for the MIPS multi-cycle control unit: opcode and funct
// constants, aluControl and pc_src encodings, and the control FSM state enum.
package mips_pkg;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // aluControl encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // pc_src encodings
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  // Loads and stores share the address-calculation and MEM phases.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder
// Combinational decode of the latched opcode/funct into the EXEC-phase
// aluControl value and a legality flag for the DECODE illegal check.
// Ports:
//   opcode_i   [5:0]  latched opcode
//   funct_i    [5:0]  latched funct (only meaningful for R-type)
//   alu_ctrl_o [2:0]  ALU operation for the EXEC phase
//   legal_o           1 = supported instruction
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       legal_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    legal_o    = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD: begin alu_ctrl_o = ALU_ADD; legal_o = 1'b1; end
          FN_SUB: begin alu_ctrl_o = ALU_SUB; legal_o = 1'b1; end
          FN_AND: begin alu_ctrl_o = ALU_AND; legal_o = 1'b1; end
          FN_OR:  begin alu_ctrl_o = ALU_OR;  legal_o = 1'b1; end
          FN_SLT: begin alu_ctrl_o = ALU_SLT; legal_o = 1'b1; end
          default: begin alu_ctrl_o = ALU_ADD; legal_o = 1'b0; end
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: begin
        alu_ctrl_o = ALU_ADD;
        legal_o    = 1'b1;
      end
      OP_BEQ: begin
        alu_ctrl_o = ALU_SUB;
        legal_o    = 1'b1;
      end
      OP_J: begin
        alu_ctrl_o = ALU_ADD;
        legal_o    = 1'b1;
      end
      default: begin
        alu_ctrl_o = ALU_ADD;
        legal_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multi-cycle control FSM for MIPS_Datapath. Sequences FETCH/DECODE/EXEC/
// MEM/WB, stalling FETCH and MEM on mem_ready. Outputs are a Moore decode of
// the registered state and the latched opcode/funct; the only input-dependent
// terms are the FETCH handshake (mem_ready) and the BEQ pc_write (zero).
// Optional feature macro: MIPS_CTRL_ILLEGAL_TRAP_EN adds the illegal_op port
// and a TRAP state; otherwise illegal instructions retire as NOPs.
// Ports:
//   clk, reset (async, active-high)
//   instruction[31:0], zero, mem_ready       inputs
//   ir_write, pc_write, pc_src[1:0]          PC / IR control
//   regWrite, memRead, memWrite, branch      datapath strobes
//   aluControl[2:0], alu_src, reg_dst, mem_to_reg
//   state[2:0]                               debug view of FSM state
//   illegal_op                               only with the trap macro
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        regWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic        branch,
  output logic [2:0]  aluControl,
  output logic        alu_src,
  output logic        reg_dst,
  output logic        mem_to_reg,
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  output logic        illegal_op,
`endif
  output logic [2:0]  state
);

  state_e     state_q, state_d;
  logic [5:0] op_q, funct_q;
  logic       load_ir;
  logic [2:0] dec_alu;
  logic       dec_legal;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^instruction[25:6];

  // IR load happens on the FETCH cycle that memory completes.
  assign load_ir = (state_q == S_FETCH) && mem_ready;

  mips_alu_decoder u_alu_dec (
    .opcode_i   (op_q),
    .funct_i    (funct_q),
    .alu_ctrl_o (dec_alu),
    .legal_o    (dec_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_ir) begin
        op_q    <= instruction[31:26];
        funct_q <= instruction[5:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op_q == OP_J)
          state_d = S_FETCH;
        else if (dec_legal)
          state_d = S_EXEC;
        else
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
      end
      S_EXEC: begin
        if (is_mem_op(op_q))
          state_d = S_MEM;
        else if ((op_q == OP_RTYPE) || (op_q == OP_ADDI))
          state_d = S_WB;
        else
          state_d = S_FETCH;
      end
      S_MEM: begin
        if (mem_ready)
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Output decode; everything is forced low while reset is high so a reset
  // mid-instruction kills any strobe in the same cycle.
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    regWrite   = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    branch     = 1'b0;
    aluControl = ALU_AND;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    illegal_op = 1'b0;
`endif
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          memRead = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          if (op_q == OP_J) begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
          end
        end
        S_EXEC: begin
          aluControl = dec_alu;
          if (is_mem_op(op_q) || (op_q == OP_ADDI))
            alu_src = 1'b1;
          if (op_q == OP_BEQ) begin
            branch   = 1'b1;
            pc_src   = PC_BRANCH;
            pc_write = zero;
          end
        end
        S_MEM: begin
          alu_src    = 1'b1;
          aluControl = ALU_ADD;
          memRead    = (op_q == OP_LW);
          memWrite   = (op_q == OP_SW);
        end
        S_WB: begin
          regWrite   = 1'b1;
          reg_dst    = (op_q == OP_RTYPE);
          mem_to_reg = (op_q == OP_LW);
        end
        S_TRAP: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
          illegal_op = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic        zero;
  logic        mem_ready;
  logic        ir_write, pc_write, regWrite, memRead, memWrite, branch;
  logic [1:0]  pc_src;
  logic [2:0]  aluControl;
  logic        alu_src, reg_dst, mem_to_reg;
  logic [2:0]  state;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif

  mips_multicycle_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .regWrite    (regWrite),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .branch      (branch),
    .aluControl  (aluControl),
    .alu_src     (alu_src),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    .illegal_op  (illegal_op),
`endif
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector for one cycle.
  typedef struct packed {
    logic [2:0] st;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       rw;
    logic       mrd;
    logic       mw;
    logic       br;
    logic [2:0] alu;
    logic       asrc;
    logic       rdst;
    logic       m2r;
    logic       ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic        mr;
    logic        z;
    logic        rst;
    exp_t        e;
  } step_t;

  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_ADDI = 4, C_J = 5, C_ILL = 6;

  step_t plan[$];
  exp_t  expq[$];
  int    total  = 0;
  int    passed = 0;
  int    cyc    = 0;

  function automatic logic rbit();
    return ($urandom() & 32'd1) != 32'd0;
  endfunction

  function automatic int cls_of(input logic [31:0] w);
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    case (op)
      6'd0:  return (fn == 6'd32 || fn == 6'd34 || fn == 6'd36 || fn == 6'd37 || fn == 6'd42) ? C_R : C_ILL;
      6'd35: return C_LW;
      6'd43: return C_SW;
      6'd4:  return C_BEQ;
      6'd8:  return C_ADDI;
      6'd2:  return C_J;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'd32: return 3'b010;
      6'd34: return 3'b110;
      6'd36: return 3'b000;
      6'd37: return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [31:0] mk_instr(input int c);
    logic [31:0] w;
    logic [5:0]  fns [5];
    fns[0] = 6'd32; fns[1] = 6'd34; fns[2] = 6'd36; fns[3] = 6'd37; fns[4] = 6'd42;
    w = $urandom();
    case (c)
      C_R:    begin w[31:26] = 6'd0; w[5:0] = fns[$urandom_range(0, 4)]; end
      C_LW:   w[31:26] = 6'd35;
      C_SW:   w[31:26] = 6'd43;
      C_BEQ:  w[31:26] = 6'd4;
      C_ADDI: w[31:26] = 6'd8;
      C_J:    w[31:26] = 6'd2;
      default: begin
        if (rbit()) w[31:26] = 6'd0;
        while (cls_of(w) != C_ILL) w = $urandom();
      end
    endcase
    return w;
  endfunction

  task automatic add_step(input logic [31:0] ins, input logic mr, input logic z,
                          input logic rst, input exp_t e);
    step_t s;
    s.ins = ins; s.mr = mr; s.z = z; s.rst = rst; s.e = e;
    plan.push_back(s);
  endtask

  task automatic add_reset(input int n);
    for (int i = 0; i < n; i++) add_step($urandom(), rbit(), rbit(), 1'b1, '0);
  endtask

  // Timeline of one instruction: fs FETCH stalls, ms MEM stalls, zero value
  // presented in EXEC. Outside FETCH the instruction bus carries junk.
  task automatic build(input logic [31:0] ins, input int fs, input int ms, input logic z);
    int   c;
    exp_t e;
    c = cls_of(ins);
    for (int i = 0; i < fs; i++) begin
      e = '0; e.mrd = 1'b1;
      add_step(ins, 1'b0, rbit(), 1'b0, e);
    end
    e = '0; e.mrd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    add_step(ins, 1'b1, rbit(), 1'b0, e);
    e = '0; e.st = 3'd1;
    if (c == C_J) begin e.pcw = 1'b1; e.pcs = 2'b10; end
    add_step($urandom(), rbit(), rbit(), 1'b0, e);
    if (c == C_J) return;
    if (c == C_ILL) begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) begin
        e = '0; e.st = 3'd5; e.ill = 1'b1;
        add_step($urandom(), rbit(), rbit(), 1'b0, e);
      end
`endif
      return;
    end
    e = '0; e.st = 3'd2;
    case (c)
      C_R:  e.alu = r_alu(ins[5:0]);
      C_BEQ: begin e.alu = 3'b110; e.br = 1'b1; e.pcs = 2'b01; e.pcw = z; end
      default: begin e.alu = 3'b010; e.asrc = 1'b1; end
    endcase
    add_step($urandom(), rbit(), (c == C_BEQ) ? z : rbit(), 1'b0, e);
    if (c == C_BEQ) return;
    if (c == C_LW || c == C_SW) begin
      for (int i = 0; i <= ms; i++) begin
        e = '0; e.st = 3'd3; e.asrc = 1'b1; e.alu = 3'b010;
        e.mrd = (c == C_LW); e.mw = (c == C_SW);
        add_step($urandom(), (i == ms), rbit(), 1'b0, e);
      end
      if (c == C_SW) return;
    end
    e = '0; e.st = 3'd4; e.rw = 1'b1;
    e.rdst = (c == C_R); e.m2r = (c == C_LW);
    add_step($urandom(), rbit(), rbit(), 1'b0, e);
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  // Single compare process: every driven cycle has one expectation.
  initial begin
    exp_t e, g;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        g = '0;
        g.st = state; g.irw = ir_write; g.pcw = pc_write; g.pcs = pc_src;
        g.rw = regWrite; g.mrd = memRead; g.mw = memWrite; g.br = branch;
        g.alu = aluControl; g.asrc = alu_src; g.rdst = reg_dst; g.m2r = mem_to_reg;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        g.ill = illegal_op;
`endif
        total++;
        if (g === e) passed++;
        else $display("FAIL cycle%0d: got st=%0d irw=%b pcw=%b pcs=%b rw=%b mrd=%b mw=%b br=%b alu=%b asrc=%b rdst=%b m2r=%b ill=%b, expected st=%0d irw=%b pcw=%b pcs=%b rw=%b mrd=%b mw=%b br=%b alu=%b asrc=%b rdst=%b m2r=%b ill=%b",
                      cyc, g.st, g.irw, g.pcw, g.pcs, g.rw, g.mrd, g.mw, g.br, g.alu, g.asrc, g.rdst, g.m2r, g.ill,
                      e.st, e.irw, e.pcw, e.pcs, e.rw, e.mrd, e.mw, e.br, e.alu, e.asrc, e.rdst, e.m2r, e.ill);
        cyc++;
      end
    end
  end

  initial begin
    int n0, c, fs, ms;
    exp_t e;
    reset = 1'b1; instruction = '0; zero = 1'b0; mem_ready = 1'b0;

    add_reset(2);

    // Directed program; literal cycle counts pin the model.
    n0 = plan.size(); build(32'h00221820, 0, 0, 1'b0);
    chk_int("add_cycles", plan.size() - n0, 4);
    chk_int("add_exec_alu", int'(plan[n0 + 2].e.alu), 2);
    chk_int("add_wb_regdst", int'(plan[n0 + 3].e.rdst), 1);
    n0 = plan.size(); build(32'h8C240004, 0, 2, 1'b0);
    chk_int("lw_stall_cycles", plan.size() - n0, 7);
    chk_int("lw_wb_m2r", int'(plan[n0 + 6].e.m2r), 1);
    n0 = plan.size(); build(32'hAC250008, 0, 0, 1'b0);
    chk_int("sw_cycles", plan.size() - n0, 4);
    n0 = plan.size(); build(32'h10220003, 0, 0, 1'b1);
    chk_int("beq_z1_cycles", plan.size() - n0, 3);
    chk_int("beq_z1_pcw", int'(plan[n0 + 2].e.pcw), 1);
    n0 = plan.size(); build(32'h10220003, 0, 0, 1'b0);
    chk_int("beq_z0_pcw", int'(plan[n0 + 2].e.pcw), 0);
    n0 = plan.size(); build(32'h0800000A, 1, 0, 1'b0);
    chk_int("j_fstall_cycles", plan.size() - n0, 3);
    chk_int("j_pcsrc", int'(plan[n0 + 2].e.pcs), 2);
`ifndef MIPS_CTRL_ILLEGAL_TRAP_EN
    n0 = plan.size(); build(32'hFC000000, 0, 0, 1'b0);
    chk_int("ill_nop_cycles", plan.size() - n0, 2);
    build(32'h00221822 | 32'h00000001, 0, 0, 1'b0);
`endif

    // SW aborted by reset in MEM.
    e = '0; e.mrd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    add_step(32'hAC250008, 1'b1, 1'b0, 1'b0, e);
    e = '0; e.st = 3'd1; add_step($urandom(), 1'b1, 1'b0, 1'b0, e);
    e = '0; e.st = 3'd2; e.alu = 3'b010; e.asrc = 1'b1; add_step($urandom(), 1'b1, 1'b0, 1'b0, e);
    e = '0; e.st = 3'd3; e.alu = 3'b010; e.asrc = 1'b1; e.mw = 1'b1; add_step($urandom(), 1'b0, 1'b0, 1'b0, e);
    add_reset(2);
    build(32'h00221820, 0, 0, 1'b0);

    // Randomized program.
    for (int i = 0; i < 150; i++) begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      c = $urandom_range(0, 5);
`else
      c = $urandom_range(0, 6);
`endif
      fs = (($urandom() & 32'd3) == 0) ? $urandom_range(1, 3) : 0;
      ms = $urandom_range(0, 3);
      build(mk_instr(c), fs, ms, rbit());
    end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    build(32'hFC000000, 0, 0, 1'b0);
    add_reset(2);
    build(32'h00221820, 0, 0, 1'b0);
`endif

    foreach (plan[i]) begin
      @(negedge clk);
      reset       = plan[i].rst;
      instruction = plan[i].ins;
      mem_ready   = plan[i].mr;
      zero        = plan[i].z;
      expq.push_back(plan[i].e);
    end
    repeat (3) @(negedge clk);
    chk_int("expect_queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
